// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: exception FSM states,
// forwarding-mux selects and PC redirect selects.
package pipeline_hazard_ctrl_pkg;

  localparam int DEF_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    VECTOR = 2'd2
  } exc_state_e;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  localparam logic [1:0] REDIR_JUMP   = 2'd0;
  localparam logic [1:0] REDIR_BRANCH = 2'd1;
  localparam logic [1:0] REDIR_VECTOR = 2'd2;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_sel.sv
// Forwarding select for one ALU operand: MEM result beats WB result; r0 never forwards.
module fwd_sel_unit
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [ADDR_W-1:0] ex_src,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic              mem_regwr,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic              wb_regwr,
  output logic [1:0]        sel
);

  // priority compare against the two younger writers
  always_comb begin
    sel = FWD_RF;
    if (mem_regwr && (mem_rd != '0) && (mem_rd == ex_src)) begin
      sel = FWD_MEM;
    end else if (wb_regwr && (wb_rd != '0) && (wb_rd == ex_src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline hazard controller: forwarding, load-use stall, jump/branch flush,
// exception drain/vector FSM and saturating stall/flush counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
  parameter int DRAIN_CYCLES = 2,
  parameter int PERF_CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_jump,
  input  logic                  id_exception,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_regwr,
  input  logic                  ex_memtoreg,
  input  logic                  ex_branch_taken,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_regwr,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_regwr,
  input  logic                  perf_clr,
  output logic                  pc_wr_en,
  output logic                  ifid_wr_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  pc_redirect,
  output logic [1:0]            pc_redirect_sel,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  epc_wr_en,
  output logic                  exc_busy,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt
);

  localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD =
    (DRAIN_CYCLES > 0) ? CNT_W'(DRAIN_CYCLES - 1) : '0;

  exc_state_e       state_r;
  exc_state_e       state_nxt_s;
  logic [CNT_W-1:0] drain_cnt_r;
  logic [CNT_W-1:0] drain_cnt_nxt_s;
  logic             load_use_s;
  logic             stall_s;
  logic [1:0]       fwd_a_s;
  logic [1:0]       fwd_b_s;

  fwd_sel_unit #(.ADDR_W(REG_ADDR_W)) u_fwd_a (
    .ex_src(ex_rs), .mem_rd(mem_rd), .mem_regwr(mem_regwr),
    .wb_rd(wb_rd), .wb_regwr(wb_regwr), .sel(fwd_a_s)
  );

  fwd_sel_unit #(.ADDR_W(REG_ADDR_W)) u_fwd_b (
    .ex_src(ex_rt), .mem_rd(mem_rd), .mem_regwr(mem_regwr),
    .wb_rd(wb_rd), .wb_regwr(wb_regwr), .sel(fwd_b_s)
  );

  // Outputs are forced low combinationally so an asserted reset silences them at once.
  assign fwd_a_sel = rst_n ? fwd_a_s : FWD_RF;
  assign fwd_b_sel = rst_n ? fwd_b_s : FWD_RF;
  assign exc_busy  = rst_n && (state_r != RUN);

  assign load_use_s = ex_regwr && ex_memtoreg && (ex_rd != '0) &&
                      ((id_uses_rs && (ex_rd == id_rs)) || (id_uses_rt && (ex_rd == id_rt)));

  // exception FSM state and drain counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RUN;
      drain_cnt_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      drain_cnt_r <= drain_cnt_nxt_s;
    end
  end

  // next-state: only RUN accepts an exception, and a taken branch squashes it
  always_comb begin
    state_nxt_s     = state_r;
    drain_cnt_nxt_s = drain_cnt_r;
    case (state_r)
      RUN: begin
        if (!ex_branch_taken && id_exception) begin
          if (DRAIN_CYCLES == 0) begin
            state_nxt_s = VECTOR;
          end else begin
            state_nxt_s     = DRAIN;
            drain_cnt_nxt_s = DRAIN_LOAD;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN: begin
        if (drain_cnt_r == '0) begin
          state_nxt_s = VECTOR;
        end else begin
          drain_cnt_nxt_s = drain_cnt_r - CNT_W'(1);
        end
      end
      VECTOR:  state_nxt_s = RUN;
      default: state_nxt_s = RUN;
    endcase
  end

  // pipeline control outputs by state and RUN priority
  always_comb begin
    pc_wr_en        = 1'b0;
    ifid_wr_en      = 1'b0;
    ifid_flush      = 1'b0;
    idex_flush      = 1'b0;
    pc_redirect     = 1'b0;
    pc_redirect_sel = REDIR_JUMP;
    epc_wr_en       = 1'b0;
    stall_s         = 1'b0;
    if (rst_n) begin
      case (state_r)
        RUN: begin
          pc_wr_en   = 1'b1;
          ifid_wr_en = 1'b1;
          if (ex_branch_taken) begin
            ifid_flush      = 1'b1;
            idex_flush      = 1'b1;
            pc_redirect     = 1'b1;
            pc_redirect_sel = REDIR_BRANCH;
          end else if (id_exception) begin
            epc_wr_en  = 1'b1;
            pc_wr_en   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use_s) begin
            pc_wr_en   = 1'b0;
            ifid_wr_en = 1'b0;
            idex_flush = 1'b1;
            stall_s    = 1'b1;
          end else if (id_jump) begin
            ifid_flush      = 1'b1;
            pc_redirect     = 1'b1;
            pc_redirect_sel = REDIR_JUMP;
          end else begin
            stall_s = 1'b0;
          end
        end
        DRAIN: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
        VECTOR: begin
          pc_wr_en        = 1'b1;
          ifid_flush      = 1'b1;
          pc_redirect     = 1'b1;
          pc_redirect_sel = REDIR_VECTOR;
        end
        default: pc_wr_en = 1'b0;
      endcase
    end else begin
      pc_wr_en = 1'b0;
    end
  end

  // saturating perf counters; clear dominates a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (perf_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_s && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + PERF_CNT_W'(1);
      end
      if (ifid_flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + PERF_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios plus random traffic
// checked against a cycle-level reference model of the hazard rules.
module tb_pipeline_hazard_ctrl;
  localparam int DRAIN_CYCLES = 2;
  localparam int PW   = 16;
  localparam int MAXC = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic id_uses_rs, id_uses_rt, id_jump, id_exception;
  logic ex_regwr, ex_memtoreg, ex_branch_taken, mem_regwr, wb_regwr, perf_clr;
  logic pc_wr_en, ifid_wr_en, ifid_flush, idex_flush, pc_redirect, epc_wr_en, exc_busy;
  logic [1:0] pc_redirect_sel, fwd_a_sel, fwd_b_sel;
  logic [PW-1:0] stall_cnt, flush_cnt;

  typedef struct packed {
    logic [12:0]   ctl;
    logic [PW-1:0] stall;
    logic [PW-1:0] flush;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  int m_drain_rem = 0;
  bit m_vec       = 1'b0;
  int m_stall     = 0;
  int m_flush     = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .DRAIN_CYCLES(DRAIN_CYCLES), .PERF_CNT_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .id_exception(id_exception),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regwr(ex_regwr),
    .ex_memtoreg(ex_memtoreg), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_regwr(mem_regwr), .wb_rd(wb_rd), .wb_regwr(wb_regwr),
    .perf_clr(perf_clr),
    .pc_wr_en(pc_wr_en), .ifid_wr_en(ifid_wr_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .pc_redirect(pc_redirect), .pc_redirect_sel(pc_redirect_sel),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .epc_wr_en(epc_wr_en),
    .exc_busy(exc_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic logic [1:0] fsel(input logic [4:0] src);
    if (mem_regwr && mem_rd != 5'd0 && mem_rd == src) return 2'd1;
    if (wb_regwr && wb_rd != 5'd0 && wb_rd == src) return 2'd2;
    return 2'd0;
  endfunction

  // Reference model: expected outputs for the current inputs, then advance one cycle.
  task automatic model_eval();
    exp_t e;
    logic pw, iw, ifl, idl, rd, epc, busy, stall, lu;
    logic [1:0] sel;
    pw = 0; iw = 0; ifl = 0; idl = 0; rd = 0; epc = 0; busy = 0; stall = 0; sel = 2'd0;
    if (!rst_n) begin
      m_drain_rem = 0; m_vec = 0; m_stall = 0; m_flush = 0;
      e.ctl = 13'd0; e.stall = '0; e.flush = '0;
      exp_q.push_back(e);
      return;
    end
    lu = ex_regwr && ex_memtoreg && ex_rd != 5'd0 &&
         ((id_uses_rs && ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));
    if (m_drain_rem > 0) begin
      ifl = 1; idl = 1; busy = 1;
      m_drain_rem--;
      if (m_drain_rem == 0) m_vec = 1;
    end else if (m_vec) begin
      pw = 1; ifl = 1; rd = 1; sel = 2'd2; busy = 1;
      m_vec = 0;
    end else begin
      pw = 1; iw = 1;
      if (ex_branch_taken) begin
        ifl = 1; idl = 1; rd = 1; sel = 2'd1;
      end else if (id_exception) begin
        epc = 1; pw = 0; ifl = 1; idl = 1;
        m_drain_rem = DRAIN_CYCLES;
        if (DRAIN_CYCLES == 0) m_vec = 1;
      end else if (lu) begin
        pw = 0; iw = 0; idl = 1; stall = 1;
      end else if (id_jump) begin
        ifl = 1; rd = 1; sel = 2'd0;
      end
    end
    e.ctl   = {pw, iw, ifl, idl, rd, sel, fsel(ex_rs), fsel(ex_rt), epc, busy};
    e.stall = PW'(m_stall);
    e.flush = PW'(m_flush);
    exp_q.push_back(e);
    if (perf_clr) begin
      m_stall = 0; m_flush = 0;
    end else begin
      if (stall && m_stall < MAXC) m_stall++;
      if (ifl && m_flush < MAXC) m_flush++;
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expectation, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    logic [12:0] act;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {pc_wr_en, ifid_wr_en, ifid_flush, idex_flush, pc_redirect, pc_redirect_sel,
             fwd_a_sel, fwd_b_sel, epc_wr_en, exc_busy};
      total++;
      if (act !== e.ctl) begin
        bad++;
        $display("FAIL ctl cyc=%0d got=%b want=%b (pcw,ifidw,ifl,idl,redir,sel,fa,fb,epc,busy)",
                 cyc, act, e.ctl);
      end
      total++;
      if ({stall_cnt, flush_cnt} !== {e.stall, e.flush}) begin
        bad++;
        $display("FAIL perf cyc=%0d got stall=%0d flush=%0d want stall=%0d flush=%0d",
                 cyc, stall_cnt, flush_cnt, e.stall, e.flush);
      end
    end
  end

  task automatic clr_in();
    id_rs = 5'd0; id_rt = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0;
    mem_rd = 5'd0; wb_rd = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_jump = 1'b0; id_exception = 1'b0;
    ex_regwr = 1'b0; ex_memtoreg = 1'b0; ex_branch_taken = 1'b0;
    mem_regwr = 1'b0; wb_regwr = 1'b0; perf_clr = 1'b0;
  endtask

  task automatic go();
    model_eval();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_load_use();
    ex_rd = 5'd3; ex_regwr = 1'b1; ex_memtoreg = 1'b1; id_rs = 5'd3; id_uses_rs = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_in();
    @(posedge clk);
    #1;
    repeat (3) go();
    rst_n = 1'b1;
    repeat (2) go();

    // load-use stall, then the released instruction flows
    set_load_use(); go();
    clr_in(); go();
    // forwarding priority and r0 exclusion
    mem_rd = 5'd5; wb_rd = 5'd5; mem_regwr = 1'b1; wb_regwr = 1'b1; ex_rs = 5'd5; ex_rt = 5'd5; go();
    mem_regwr = 1'b0; go();
    mem_regwr = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0; go();
    clr_in();
    // taken branch overrides jump and load-use
    set_load_use(); id_jump = 1'b1; ex_branch_taken = 1'b1; go();
    // load-use with jump: jump waits one cycle
    ex_branch_taken = 1'b0; go();
    clr_in(); id_jump = 1'b1; go();
    clr_in(); go();
    // exception: drain, vector, back to run
    id_exception = 1'b1; go();
    clr_in(); id_jump = 1'b1; ex_branch_taken = 1'b1; set_load_use(); go();
    id_exception = 1'b1; go();
    clr_in(); go(); go();
    // reset during the second drain cycle: no vector afterwards
    id_exception = 1'b1; go();
    clr_in(); go();
    rst_n = 1'b0; go();
    rst_n = 1'b1; go(); go(); go();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n           = ($urandom_range(0, 199) != 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rs           = 5'($urandom_range(0, 3));
      ex_rt           = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      mem_rd          = 5'($urandom_range(0, 3));
      wb_rd           = 5'($urandom_range(0, 3));
      id_uses_rs      = 1'($urandom_range(0, 1));
      id_uses_rt      = 1'($urandom_range(0, 1));
      ex_regwr        = 1'($urandom_range(0, 1));
      ex_memtoreg     = 1'($urandom_range(0, 1));
      mem_regwr       = 1'($urandom_range(0, 1));
      wb_regwr        = 1'($urandom_range(0, 1));
      id_jump         = ($urandom_range(0, 5) == 0);
      id_exception    = ($urandom_range(0, 19) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      perf_clr        = ($urandom_range(0, 49) == 0);
      go();
    end

    // flush counter saturation, then clear
    rst_n = 1'b1;
    clr_in(); perf_clr = 1'b1; go();
    clr_in(); id_jump = 1'b1;
    repeat ((1 << PW) + 3) go();
    perf_clr = 1'b1; go();
    clr_in(); go(); go();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
